// File: rtl/fwd_hazard_tracker_if.sv
// ----------------------------------------------------------------------------
// fwd_hazard_tracker_if
// Groups the ID-stage inputs and the forwarding/hazard outputs of
// fwd_hazard_tracker into one bundle.
//
// Signal qualification: there is no valid/ready handshake here. id_valid
// qualifies all id_* fields in the same cycle. The pipeline must hold the id_*
// fields stable while hazard_stall=1. flush kills the ID instruction and
// overrides any stall in that cycle.
//
// master modport: pipeline side (drives ID inputs, reads fwd/hazard outputs)
// slave  modport: tracker side
// ----------------------------------------------------------------------------
interface fwd_hazard_tracker_if #(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 3,
    parameter int FWD_STAGES = 2,
    parameter int CNT_W      = 16
);
    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    logic                          enable_forward;
    logic                          id_valid;
    logic [NUM_SRC*REG_ADDR_W-1:0] id_src;
    logic [NUM_SRC-1:0]            id_src_used;
    logic [REG_ADDR_W-1:0]         id_dest;
    logic                          id_wb_en;
    logic                          id_mem_r_en;
    logic                          flush;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
    logic                          hazard_stall;
    logic [CNT_W-1:0]              stall_cnt;
    logic [CNT_W-1:0]              fwd_cnt;

    modport master (
        output enable_forward, id_valid, id_src, id_src_used, id_dest,
               id_wb_en, id_mem_r_en, flush,
        input  fwd_sel, hazard_stall, stall_cnt, fwd_cnt
    );

    modport slave (
        input  enable_forward, id_valid, id_src, id_src_used, id_dest,
               id_wb_en, id_mem_r_en, flush,
        output fwd_sel, hazard_stall, stall_cnt, fwd_cnt
    );
endinterface

// File: rtl/fwd_hazard_tracker.sv
// ----------------------------------------------------------------------------
// fwd_hazard_tracker
// Forwarding + hazard unit for the ID stage. Keeps a private shift pipeline of
// write tags {v, dest, wb, ld} for FWD_STAGES stages after ID (stage 0 = EXE).
// For every source operand it selects the youngest in-flight producer, raises
// hazard_stall on load-use (forwarding on) or any RAW (forwarding off), and
// keeps saturating stall / forward performance counters.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active-high
//   bus  - fwd_hazard_tracker_if.slave: ID inputs, fwd_sel, hazard_stall,
//          stall_cnt, fwd_cnt
// ----------------------------------------------------------------------------
module fwd_hazard_tracker #(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 3,
    parameter int FWD_STAGES = 2,
    parameter int CNT_W      = 16
) (
    input logic                clk,
    input logic                rst,
    fwd_hazard_tracker_if.slave bus
);
    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] dest;
        logic                  wb;
        logic                  ld;
    } tag_t;

    tag_t                     tags [FWD_STAGES];
    logic [NUM_SRC-1:0]       found;
    logic [NUM_SRC-1:0]       haz;
    logic [SEL_W-1:0]         cand [NUM_SRC];
    logic [NUM_SRC*SEL_W-1:0] sel;
    logic                     stall;
    logic [CNT_W-1:0]         stall_cnt_q;
    logic [CNT_W-1:0]         fwd_cnt_q;

    // Youngest producer per operand: scan from oldest to youngest so the last
    // hit (lowest stage index) is the one that sticks.
    always_comb begin
        found = '0;
        haz   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand[i] = '0;
            for (int k = FWD_STAGES - 1; k >= 0; k--) begin
                if (bus.id_valid && bus.id_src_used[i] && tags[k].v && tags[k].wb &&
                    (tags[k].dest == bus.id_src[i*REG_ADDR_W +: REG_ADDR_W])) begin
                    found[i] = 1'b1;
                    cand[i]  = SEL_W'(k + 1);
                end
            end
            // With forwarding, only a load still in EXE cannot be bypassed.
            if (bus.enable_forward)
                haz[i] = found[i] && (cand[i] == SEL_W'(1)) && tags[0].ld;
            else
                haz[i] = found[i];
        end
    end

    // flush kills the ID instruction, so it never needs to wait.
    always_comb begin
        stall = !bus.flush && (|haz);
        sel   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.enable_forward && found[i] && !stall)
                sel[i*SEL_W +: SEL_W] = cand[i];
        end
    end

    // Tag pipeline never freezes; a stalled or killed ID slot enters as a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < FWD_STAGES; k++)
                tags[k] <= '0;
        end else begin
            for (int k = 1; k < FWD_STAGES; k++)
                tags[k] <= tags[k-1];
            if (bus.flush || stall || !bus.id_valid)
                tags[0] <= '0;
            else
                tags[0] <= '{v: 1'b1, dest: bus.id_dest, wb: bus.id_wb_en, ld: bus.id_mem_r_en};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (bus.id_valid && !bus.flush && !stall && (|sel) &&
                (fwd_cnt_q != {CNT_W{1'b1}}))
                fwd_cnt_q <= fwd_cnt_q + 1'b1;
        end
    end

    assign bus.fwd_sel      = sel;
    assign bus.hazard_stall = stall;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.fwd_cnt      = fwd_cnt_q;
endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// ----------------------------------------------------------------------------
// tb_fwd_hazard_tracker
// Drives fwd_hazard_tracker with directed scenarios and randomized ID traffic.
// A reference model keeps the history of what entered EXE each cycle and
// derives fwd_sel / hazard_stall / counters from it. A second instance with
// 2-bit counters shares the inputs so saturation is exercised.
// ----------------------------------------------------------------------------
module tb_fwd_hazard_tracker;
    localparam int RW    = 4;
    localparam int NS    = 3;
    localparam int FS    = 2;
    localparam int SEL_W = $clog2(FS + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fwd_hazard_tracker_if #(.REG_ADDR_W(RW), .NUM_SRC(NS), .FWD_STAGES(FS), .CNT_W(16)) bus ();
    fwd_hazard_tracker_if #(.REG_ADDR_W(RW), .NUM_SRC(NS), .FWD_STAGES(FS), .CNT_W(2))  bus2 ();

    fwd_hazard_tracker #(.REG_ADDR_W(RW), .NUM_SRC(NS), .FWD_STAGES(FS), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    fwd_hazard_tracker #(.REG_ADDR_W(RW), .NUM_SRC(NS), .FWD_STAGES(FS), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .bus(bus2.slave)
    );

    assign bus2.enable_forward = bus.enable_forward;
    assign bus2.id_valid       = bus.id_valid;
    assign bus2.id_src         = bus.id_src;
    assign bus2.id_src_used    = bus.id_src_used;
    assign bus2.id_dest        = bus.id_dest;
    assign bus2.id_wb_en       = bus.id_wb_en;
    assign bus2.id_mem_r_en    = bus.id_mem_r_en;
    assign bus2.flush          = bus.flush;

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [SEL_W-1:0] sel_of(input int i);
        return bus.fwd_sel[i*SEL_W +: SEL_W];
    endfunction

    // ---------------- reference model ----------------
    // hist[a] = what entered EXE a cycles ago (index 0 = currently in EXE).
    typedef struct {
        bit v;
        int dest;
        bit wb;
        bit ld;
    } ent_t;

    ent_t hist[$];
    int   m_stall16 = 0, m_fwd16 = 0, m_stall2 = 0, m_fwd2 = 0;
    bit   m_stall_now = 0;
    logic [NS*SEL_W-1:0] exp_q[$];

    always @(negedge clk) begin
        if (rst) begin
            hist.delete();
            for (int a = 0; a < FS; a++) hist.push_back('{v: 0, dest: 0, wb: 0, ld: 0});
            m_stall16 = 0; m_fwd16 = 0; m_stall2 = 0; m_fwd2 = 0;
            m_stall_now = 0;
            chk("rst_fwd_sel",   64'(bus.fwd_sel), 64'd0);
            chk("rst_stall",     64'(bus.hazard_stall), 64'd0);
            chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
            chk("rst_fwd_cnt",   64'(bus.fwd_cnt), 64'd0);
            chk("rst_sat_cnts",  64'({bus2.stall_cnt, bus2.fwd_cnt}), 64'd0);
        end else begin
            int  youngest [NS];
            bit  any_haz;
            bit  stall;
            logic [NS*SEL_W-1:0] exp_sel;
            any_haz = 0;
            exp_sel = '0;
            for (int i = 0; i < NS; i++) begin
                int src;
                src = int'(bus.id_src[i*RW +: RW]);
                youngest[i] = -1;
                if (bus.id_valid && bus.id_src_used[i]) begin
                    for (int a = 0; a < FS; a++) begin
                        if (youngest[i] < 0 && hist[a].v && hist[a].wb && hist[a].dest == src)
                            youngest[i] = a;
                    end
                end
                if (youngest[i] >= 0) begin
                    if (!bus.enable_forward) any_haz = 1;
                    else if (youngest[i] == 0 && hist[0].ld) any_haz = 1;
                end
            end
            stall = !bus.flush && any_haz;
            for (int i = 0; i < NS; i++)
                if (bus.enable_forward && youngest[i] >= 0 && !stall)
                    exp_sel[i*SEL_W +: SEL_W] = SEL_W'(youngest[i] + 1);
            exp_q.push_back(exp_sel);

            chk("fwd_sel",   64'(bus.fwd_sel), 64'(exp_q.pop_front()));
            chk("stall",     64'(bus.hazard_stall), 64'(stall));
            chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_stall16));
            chk("fwd_cnt",   64'(bus.fwd_cnt), 64'(m_fwd16));
            chk("sat_stall_cnt", 64'(bus2.stall_cnt), 64'(m_stall2));
            chk("sat_fwd_cnt",   64'(bus2.fwd_cnt), 64'(m_fwd2));

            if (stall) begin
                if (m_stall16 < 65535) m_stall16++;
                if (m_stall2 < 3) m_stall2++;
            end
            if (bus.id_valid && !bus.flush && !stall && exp_sel != '0) begin
                if (m_fwd16 < 65535) m_fwd16++;
                if (m_fwd2 < 3) m_fwd2++;
            end
            hist.push_front('{v: (bus.id_valid && !bus.flush && !stall),
                              dest: int'(bus.id_dest), wb: bus.id_wb_en, ld: bus.id_mem_r_en});
            hist.pop_back();
            m_stall_now = stall;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic v, input logic [RW-1:0] s0, input logic [RW-1:0] s1,
                       input logic [RW-1:0] s2, input logic [NS-1:0] used,
                       input logic [RW-1:0] d, input logic wb, input logic ld, input logic fl);
        @(posedge clk); #1;
        bus.id_valid    = v;
        bus.id_src      = {s2, s1, s0};
        bus.id_src_used = used;
        bus.id_dest     = d;
        bus.id_wb_en    = wb;
        bus.id_mem_r_en = ld;
        bus.flush       = fl;
    endtask

    task automatic idle();
        cyc(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic ef);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.enable_forward = ef;
        bus.id_valid = 1'b0; bus.id_src = '0; bus.id_src_used = '0; bus.id_dest = '0;
        bus.id_wb_en = 1'b0; bus.id_mem_r_en = 1'b0; bus.flush = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.enable_forward = 1'b1;
        bus.id_valid = 1'b0; bus.id_src = '0; bus.id_src_used = '0; bus.id_dest = '0;
        bus.id_wb_en = 1'b0; bus.id_mem_r_en = 1'b0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);

        // 1: reset then idle
        do_reset(1'b1);
        idle();
        @(negedge clk);
        chk("t1_sel", 64'(bus.fwd_sel), 64'd0);
        chk("t1_stall", 64'(bus.hazard_stall), 64'd0);
        chk("t1_cnts", 64'({bus.stall_cnt, bus.fwd_cnt}), 64'd0);

        // 2: forward from EXE
        do_reset(1'b1);
        cyc(1, 0, 0, 0, 3'b000, 4'd3, 1, 0, 0);
        cyc(1, 4'd3, 0, 0, 3'b001, 4'd0, 0, 0, 0);
        @(negedge clk);
        chk("t2_sel0", 64'(sel_of(0)), 64'd1);
        chk("t2_stall", 64'(bus.hazard_stall), 64'd0);
        idle();
        @(negedge clk);
        chk("t2_fwd_cnt", 64'(bus.fwd_cnt), 64'd1);

        // 3: youngest producer wins
        do_reset(1'b1);
        cyc(1, 0, 0, 0, 3'b000, 4'd5, 1, 0, 0);
        cyc(1, 0, 0, 0, 3'b000, 4'd5, 1, 0, 0);
        cyc(1, 0, 4'd5, 0, 3'b010, 4'd0, 0, 0, 0);
        @(negedge clk);
        chk("t3_sel1", 64'(sel_of(1)), 64'd1);
        chk("t3_sel0_unused", 64'(sel_of(0)), 64'd0);

        // 4: load-use, one stall cycle then forward from MEM/WB stage
        do_reset(1'b1);
        cyc(1, 0, 0, 0, 3'b000, 4'd2, 1, 1, 0);
        cyc(1, 4'd2, 0, 0, 3'b001, 4'd7, 1, 0, 0);
        @(negedge clk);
        chk("t4_stall", 64'(bus.hazard_stall), 64'd1);
        chk("t4_sel_during_stall", 64'(bus.fwd_sel), 64'd0);
        cyc(1, 4'd2, 0, 0, 3'b001, 4'd7, 1, 0, 0);
        @(negedge clk);
        chk("t4_stall_clear", 64'(bus.hazard_stall), 64'd0);
        chk("t4_sel0", 64'(sel_of(0)), 64'd2);
        chk("t4_stall_cnt", 64'(bus.stall_cnt), 64'd1);

        // 5: forwarding off, stall until producer leaves WB
        do_reset(1'b0);
        cyc(1, 0, 0, 0, 3'b000, 4'd4, 1, 0, 0);
        cyc(1, 4'd4, 0, 0, 3'b001, 4'd0, 0, 0, 0);
        @(negedge clk);
        chk("t5_stall_a", 64'(bus.hazard_stall), 64'd1);
        cyc(1, 4'd4, 0, 0, 3'b001, 4'd0, 0, 0, 0);
        @(negedge clk);
        chk("t5_stall_b", 64'(bus.hazard_stall), 64'd1);
        cyc(1, 4'd4, 0, 0, 3'b001, 4'd0, 0, 0, 0);
        @(negedge clk);
        chk("t5_stall_clear", 64'(bus.hazard_stall), 64'd0);
        chk("t5_sel", 64'(bus.fwd_sel), 64'd0);
        chk("t5_stall_cnt", 64'(bus.stall_cnt), 64'd2);

        // 6: flush during load-use; unused operand never forwards
        do_reset(1'b1);
        cyc(1, 0, 0, 0, 3'b000, 4'd2, 1, 1, 0);
        cyc(1, 4'd2, 0, 0, 3'b001, 4'd9, 1, 0, 1);
        @(negedge clk);
        chk("t6_flush_stall", 64'(bus.hazard_stall), 64'd0);
        cyc(1, 4'd2, 4'd2, 0, 3'b001, 4'd0, 0, 0, 0);
        @(negedge clk);
        chk("t6_stall", 64'(bus.hazard_stall), 64'd0);
        chk("t6_sel0_from_stage1", 64'(sel_of(0)), 64'd2);
        chk("t6_sel1_unused", 64'(sel_of(1)), 64'd0);
        chk("t6_cnts", 64'({bus.stall_cnt, bus.fwd_cnt}), 64'd0);

        // randomized traffic with mid-run resets and forwarding toggles
        do_reset(1'b1);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 249) == 0) begin
                rst = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) bus.enable_forward = ~bus.enable_forward;
            // a stalled ID instruction is held by the pipeline
            if (!m_stall_now || rst) begin
                bus.id_valid    = ($urandom_range(0, 9) != 0);
                bus.id_src      = {RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                                   RW'($urandom_range(0, 3))};
                bus.id_src_used = NS'($urandom_range(0, 7));
                bus.id_dest     = RW'($urandom_range(0, 3));
                bus.id_wb_en    = ($urandom_range(0, 3) != 0);
                bus.id_mem_r_en = ($urandom_range(0, 2) == 0);
                bus.flush       = ($urandom_range(0, 9) == 0);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
